fpga_status_led_ctrl: RTL and testbench
=======================================

FPGA_STATUS_LED_CTRL -- requirements
Module: fpga_status_led_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_LED, default 4, giving the number of independent LED channels (1..16).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 27, giving the width of the free-running prescaler (8..32).
REQ-003 The block SHALL have parameter STRETCH_CYCLES, default 1000000, giving the event-stretch length in clk_i cycles (>=1).
REQ-004 The block SHALL have parameter FAIL_BLINK_BIT, default CNT_WIDTH-4, giving the prescaler bit that drives fail-status blinking.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port clk_i, input, 1 bit: the sole clock.
REQ-007 The block SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-008 The block SHALL have port mode_i, input, 2*NUM_LED bits: per-channel mode, where 0=OFF, 1=ON, 2=BLINK and 3=EVENT.
REQ-009 The block SHALL have port div_sel_i, input, 5*NUM_LED bits: per-channel prescaler bit index used in BLINK mode.
REQ-010 The block SHALL have port event_i, input, NUM_LED bits: per-channel event strobe.
REQ-011 The block SHALL have port exit_valid_i, input, 1 bit: the program-exit flag.
REQ-012 The block SHALL have port exit_value_i, input, 1 bit: the exit status LSB, where 0 means pass.
REQ-013 The block SHALL have port led_o, output, NUM_LED bits: registered LED drive.
REQ-014 The block SHALL have port heartbeat_o, output, 1 bit: the prescaler MSB.
REQ-015 The block SHALL have port exit_latched_o, output, 1 bit: high once an exit has been captured.
REQ-016 The block SHALL have port exit_pass_o, output, 1 bit: the captured pass status.

Function
REQ-017 The prescaler SHALL increment by 1 every cycle and wrap from 2^CNT_WIDTH-1 to 0; heartbeat_o SHALL equal its MSB.
REQ-018 led_o SHALL be registered, so that a change on mode_i, div_sel_i or event_i appears on led_o exactly 1 cycle later.
REQ-019 OFF mode SHALL drive the channel's LED 0, and ON mode SHALL drive it 1.
REQ-020 BLINK mode SHALL drive the LED from prescaler bit div_sel; a div_sel >= CNT_WIDTH SHALL clamp to CNT_WIDTH-1.
REQ-021 EVENT mode SHALL follow these rules:
- event_i=1 loads that channel's stretch counter with STRETCH_CYCLES-1 and drives the LED 1.
- The LED then stays 1 while the counter is nonzero; the counter decrements once per cycle and saturates at 0.
- A new event while the counter is nonzero reloads the counter (retrigger).
REQ-022 The stretch counter SHALL run in every mode, so that switching into EVENT mode mid-stretch shows the remaining stretch.
REQ-023 The exit FSM SHALL have states RUN, EXIT_PASS and EXIT_FAIL:
- In RUN, exit_valid_i=1 moves to EXIT_PASS if exit_value_i=0, else to EXIT_FAIL.
- EXIT_PASS and EXIT_FAIL are sticky until reset; later exit_valid_i pulses and exit_value_i changes are ignored.
REQ-024 In EXIT_PASS, all of led_o SHALL be 1; in EXIT_FAIL, all of led_o SHALL equal prescaler bit FAIL_BLINK_BIT. Both overrides apply regardless of mode_i.
REQ-025 exit_latched_o SHALL be 1 in EXIT_PASS and EXIT_FAIL, and exit_pass_o SHALL be 1 only in EXIT_PASS; both are registered and update 1 cycle after exit_valid_i is sampled.
REQ-026 When the prescaler wraps on the same cycle as an exit capture, the capture SHALL take effect normally; no interaction is allowed between the two.

Reset
REQ-027 While rst_i=1 at a clk_i edge, the following SHALL all be 0 on the next cycle:
- prescaler, all stretch counters and the FSM state (RUN);
- led_o, heartbeat_o, exit_latched_o and exit_pass_o.
REQ-028 Asserting rst_i mid-stretch or in an exit state SHALL abort the stretch and clear the exit capture, with no residual state.
REQ-029 event_i and exit_valid_i SHALL be ignored during cycles with rst_i=1.

Structure
REQ-030 Shared package fpga_status_pkg SHALL hold the led_mode_e enum (OFF/ON/BLINK/EVENT, 2 bits) and the exit_state_e enum (RUN/EXIT_PASS/EXIT_FAIL).
REQ-031 The per-channel stretcher SHALL be sub-module led_pulse_stretch, parameterised by STRETCH_CYCLES and instantiated NUM_LED times with a generate loop.
REQ-032 The stretch counter width SHALL be $clog2(STRETCH_CYCLES+1).

Verification
The bench SHALL use CNT_WIDTH=8, STRETCH_CYCLES=4, FAIL_BLINK_BIT=2 and NUM_LED=4.
REQ-033 Reset then idle: after rst_i drops, the bench SHALL check that heartbeat_o toggles every 128 cycles and that all led_o bits are 0 with mode 0.
REQ-034 BLINK: mode=2 and div_sel=1 on ch0 -> led_o[0] SHALL toggle every 2 cycles in phase with prescaler bit 1; div_sel=31 -> led_o[0] SHALL behave as div_sel=7.
REQ-035 EVENT: a 1-cycle event_i[2] -> led_o[2] SHALL be high for exactly 4 cycles; a retrigger on the 3rd high cycle SHALL extend the pulse to 6 cycles total.
REQ-036 Exit fail: exit_valid_i=1 with exit_value_i=1 -> the next cycle SHALL show exit_latched_o=1 and exit_pass_o=0, with all led_o toggling every 4 cycles. A later pass exit SHALL be ignored.
REQ-037 Exit pass, then reset: pass exit -> all of led_o SHALL read 1111b; rst_i for 1 cycle -> all outputs SHALL be 0 and the FSM SHALL be back in RUN.
REQ-038 Reset mid-stretch: rst_i on the 2nd stretch cycle -> led_o[2] SHALL read 0 on the next cycle and stay 0 afterwards.

Source files
------------

// File: rtl/fpga_status_pkg.sv
// Shared types and helpers for the status LED controller: LED channel modes,
// the exit-capture FSM states and small per-channel decode functions.
package fpga_status_pkg;

   localparam int unsigned MODE_W    = 2;
   localparam int unsigned DIV_SEL_W = 5;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      ON    = 2'd1,
      BLINK = 2'd2,
      EVENT = 2'd3
   } led_mode_e;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      EXIT_PASS = 2'd1,
      EXIT_FAIL = 2'd2
   } exit_state_e;

   // Out-of-range selects fall back to the slowest prescaler bit.
   function automatic logic [DIV_SEL_W-1:0] clamp_div_sel(
      input logic [DIV_SEL_W-1:0] sel,
      input int unsigned          cnt_width
   );
      if (32'(sel) >= cnt_width) begin
         return DIV_SEL_W'(cnt_width - 1);
      end
      return sel;
   endfunction

   function automatic logic led_mode_value(
      input led_mode_e mode,
      input logic      blink_bit,
      input logic      stretch_on
   );
      logic val;
      val = 1'b0;
      case (mode)
         OFF:     val = 1'b0;
         ON:      val = 1'b1;
         BLINK:   val = blink_bit;
         EVENT:   val = stretch_on;
         default: val = 1'b0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/led_pulse_stretch.sv
// Stretches a single-cycle event strobe into a pulse of STRETCH_CYCLES cycles;
// a new strobe while the pulse is running restarts it.
module led_pulse_stretch #(
   parameter int STRETCH_CYCLES = 1000000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic event_i,
   output logic active_o
);

   localparam int CW = $clog2(STRETCH_CYCLES + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // The strobe cycle itself is the first lit cycle, hence the load of N-1.
   always_comb begin
      cnt_d = cnt_q;
      if (event_i) begin
         cnt_d = CW'(STRETCH_CYCLES - 1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign active_o = event_i | (cnt_q != '0);

endmodule

// File: rtl/fpga_status_led_ctrl.sv
// Board status LED controller: per-channel OFF/ON/BLINK/EVENT drive, a
// free-running heartbeat prescaler and a sticky program-exit indicator.
module fpga_status_led_ctrl
   import fpga_status_pkg::*;
#(
   parameter int NUM_LED        = 4,
   parameter int CNT_WIDTH      = 27,
   parameter int STRETCH_CYCLES = 1000000,
   parameter int FAIL_BLINK_BIT = CNT_WIDTH - 4
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [MODE_W*NUM_LED-1:0]      mode_i,
   input  logic [DIV_SEL_W*NUM_LED-1:0]   div_sel_i,
   input  logic [NUM_LED-1:0]             event_i,
   input  logic                           exit_valid_i,
   input  logic                           exit_value_i,
   output logic [NUM_LED-1:0]             led_o,
   output logic                           heartbeat_o,
   output logic                           exit_latched_o,
   output logic                           exit_pass_o
);

   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;
   exit_state_e          state_q;
   exit_state_e          state_d;
   logic [NUM_LED-1:0]   led_q;
   logic [NUM_LED-1:0]   led_d;
   logic [NUM_LED-1:0]   chan_led;
   logic [NUM_LED-1:0]   stretch_on;

   always_comb begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
   end

   for (genvar gi = 0; gi < NUM_LED; gi++) begin : g_chan
      led_mode_e            mode;
      logic [DIV_SEL_W-1:0] sel;
      logic                 blink;

      assign mode  = led_mode_e'(mode_i[MODE_W*gi +: MODE_W]);
      assign sel   = clamp_div_sel(div_sel_i[DIV_SEL_W*gi +: DIV_SEL_W], CNT_WIDTH);
      // Sampling the next prescaler value keeps the registered LED in phase
      // with the prescaler bit it follows.
      assign blink = |(cnt_d & (CNT_WIDTH'(1) << sel));

      led_pulse_stretch #(
         .STRETCH_CYCLES(STRETCH_CYCLES)
      ) u_stretch (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .event_i  (event_i[gi]),
         .active_o (stretch_on[gi])
      );

      assign chan_led[gi] = led_mode_value(mode, blink, stretch_on[gi]);
   end

   always_comb begin
      state_d = state_q;
      if ((state_q == RUN) && exit_valid_i) begin
         state_d = exit_value_i ? EXIT_FAIL : EXIT_PASS;
      end
   end

   always_comb begin
      led_d = chan_led;
      case (state_d)
         EXIT_PASS: led_d = '1;
         EXIT_FAIL: led_d = {NUM_LED{cnt_d[FAIL_BLINK_BIT]}};
         default:   led_d = chan_led;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         state_q <= RUN;
         led_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
         led_q   <= led_d;
      end
   end

   assign led_o          = led_q;
   assign heartbeat_o    = cnt_q[CNT_WIDTH-1];
   assign exit_latched_o = (state_q == EXIT_PASS) || (state_q == EXIT_FAIL);
   assign exit_pass_o    = (state_q == EXIT_PASS);

endmodule

// File: tb/tb_fpga_status_led_ctrl.sv
// Directed self-checking bench for fpga_status_led_ctrl with a small prescaler
// and short stretch so every mode and the exit overrides are reachable quickly.
module tb_fpga_status_led_ctrl;

   localparam int NUM_LED        = 4;
   localparam int CNT_WIDTH      = 8;
   localparam int STRETCH_CYCLES = 4;
   localparam int FAIL_BLINK_BIT = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [2*NUM_LED-1:0] mode_i;
   logic [5*NUM_LED-1:0] div_sel_i;
   logic [NUM_LED-1:0]   event_i;
   logic                 exit_valid_i;
   logic                 exit_value_i;
   logic [NUM_LED-1:0]   led_o;
   logic                 heartbeat_o;
   logic                 exit_latched_o;
   logic                 exit_pass_o;

   logic [7:0] presc_m;
   int         n_cmp = 0;
   int         n_mis = 0;

   fpga_status_led_ctrl #(
      .NUM_LED        (NUM_LED),
      .CNT_WIDTH      (CNT_WIDTH),
      .STRETCH_CYCLES (STRETCH_CYCLES),
      .FAIL_BLINK_BIT (FAIL_BLINK_BIT)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .mode_i         (mode_i),
      .div_sel_i      (div_sel_i),
      .event_i        (event_i),
      .exit_valid_i   (exit_valid_i),
      .exit_value_i   (exit_value_i),
      .led_o          (led_o),
      .heartbeat_o    (heartbeat_o),
      .exit_latched_o (exit_latched_o),
      .exit_pass_o    (exit_pass_o)
   );

   always #5 clk = ~clk;

   // Reference prescaler: cleared by reset, +1 per cycle, wraps at 256.
   always @(posedge clk) begin
      if (rst) presc_m <= 8'd0;
      else     presc_m <= presc_m + 8'd1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      int         last_toggle;
      int         toggles;
      int         guard;
      logic       hb_prev;
      logic [6:0] pat_single;
      logic [8:0] pat_retrig;

      last_toggle = -1;
      toggles     = 0;
      hb_prev     = 1'b0;
      pat_single  = 7'b000_1111;
      pat_retrig  = 9'b0_0011_1111;

      rst          = 1'b1;
      mode_i       = '0;
      div_sel_i    = '0;
      event_i      = '0;
      exit_valid_i = 1'b0;
      exit_value_i = 1'b0;
      repeat (3) tick();
      chk("rst_led", 32'(led_o), 32'd0);
      chk("rst_hb", 32'(heartbeat_o), 32'd0);
      chk("rst_latched", 32'(exit_latched_o), 32'd0);
      chk("rst_pass", 32'(exit_pass_o), 32'd0);
      $display("reset state checked");

      rst = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         tick();
         chk("hb_msb", 32'(heartbeat_o), 32'(presc_m[7]));
         chk("idle_led", 32'(led_o), 32'd0);
         if (heartbeat_o !== hb_prev) begin
            if (last_toggle >= 0) chk("hb_period", 32'(c - last_toggle), 32'd128);
            last_toggle = c;
            hb_prev     = heartbeat_o;
            toggles++;
         end
      end
      chk("hb_toggle_count", 32'(toggles), 32'd2);
      $display("heartbeat/idle: %0d toggles", toggles);

      mode_i    = 8'h02;
      div_sel_i = 20'd1;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("blink_div1", 32'(led_o[0]), 32'(presc_m[1]));
         chk("blink_others", 32'(led_o[3:1]), 32'd0);
      end
      $display("blink div_sel=1 checked");

      div_sel_i = 20'd31;
      tick();
      for (int i = 0; i < 260; i++) begin
         tick();
         chk("blink_clamp", 32'(led_o[0]), 32'(presc_m[7]));
      end
      $display("blink div_sel=31 clamp checked");

      mode_i = 8'h04;
      tick();
      chk("on_latency", 32'(led_o), 32'h2);
      mode_i = 8'h00;
      tick();
      chk("off_latency", 32'(led_o), 32'h0);
      $display("on/off latency checked");

      mode_i = 8'h30;
      tick();
      chk("evt_idle", 32'(led_o), 32'h0);
      event_i = 4'b0100;
      for (int i = 0; i < 7; i++) begin
         tick();
         event_i = 4'b0000;
         chk("evt_single", 32'(led_o), pat_single[i] ? 32'h4 : 32'h0);
      end
      $display("event single pulse checked");

      event_i = 4'b0100;
      for (int i = 0; i < 9; i++) begin
         tick();
         event_i = (i == 1) ? 4'b0100 : 4'b0000;
         chk("evt_retrig", 32'(led_o), pat_retrig[i] ? 32'h4 : 32'h0);
      end
      $display("event retrigger checked");

      event_i = 4'b0100;
      tick();
      event_i = 4'b0000;
      chk("evt_pre_rst1", 32'(led_o[2]), 32'd1);
      tick();
      chk("evt_pre_rst2", 32'(led_o[2]), 32'd1);
      rst     = 1'b1;
      event_i = 4'b0100;
      tick();
      chk("rst_mid_stretch", 32'(led_o[2]), 32'd0);
      chk("rst_mid_hb", 32'(heartbeat_o), 32'd0);
      rst     = 1'b0;
      event_i = 4'b0000;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rst_no_residual", 32'(led_o), 32'd0);
      end
      $display("reset mid-stretch checked");

      mode_i = 8'h55;
      guard  = 0;
      while ((presc_m != 8'hFF) && (guard < 300)) begin
         tick();
         guard++;
      end
      chk("hb_before_wrap", 32'(heartbeat_o), 32'd1);
      exit_valid_i = 1'b1;
      exit_value_i = 1'b1;
      tick();
      exit_valid_i = 1'b0;
      chk("fail_latched", 32'(exit_latched_o), 32'd1);
      chk("fail_pass", 32'(exit_pass_o), 32'd0);
      chk("fail_wrap_hb", 32'(heartbeat_o), 32'd0);
      chk("fail_led0", 32'(led_o), 32'({4{presc_m[2]}}));
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("fail_blink", 32'(led_o), 32'({4{presc_m[2]}}));
      end
      exit_valid_i = 1'b1;
      exit_value_i = 1'b0;
      tick();
      exit_valid_i = 1'b0;
      chk("fail_sticky_latched", 32'(exit_latched_o), 32'd1);
      chk("fail_sticky_pass", 32'(exit_pass_o), 32'd0);
      tick();
      chk("fail_sticky_led", 32'(led_o), 32'({4{presc_m[2]}}));
      $display("exit fail checked");

      rst = 1'b1;
      tick();
      rst    = 1'b0;
      mode_i = 8'h00;
      chk("rst2_led", 32'(led_o), 32'd0);
      chk("rst2_latched", 32'(exit_latched_o), 32'd0);
      exit_valid_i = 1'b1;
      exit_value_i = 1'b0;
      tick();
      exit_valid_i = 1'b0;
      chk("pass_led", 32'(led_o), 32'hF);
      chk("pass_latched", 32'(exit_latched_o), 32'd1);
      chk("pass_pass", 32'(exit_pass_o), 32'd1);
      tick();
      chk("pass_led_hold", 32'(led_o), 32'hF);
      rst = 1'b1;
      tick();
      chk("rst3_led", 32'(led_o), 32'd0);
      chk("rst3_hb", 32'(heartbeat_o), 32'd0);
      chk("rst3_latched", 32'(exit_latched_o), 32'd0);
      chk("rst3_pass", 32'(exit_pass_o), 32'd0);
      rst = 1'b0;
      tick();
      chk("run_led", 32'(led_o), 32'd0);
      chk("run_latched", 32'(exit_latched_o), 32'd0);
      exit_valid_i = 1'b1;
      exit_value_i = 1'b1;
      tick();
      exit_valid_i = 1'b0;
      chk("recapture_latched", 32'(exit_latched_o), 32'd1);
      chk("recapture_pass", 32'(exit_pass_o), 32'd0);
      $display("exit pass and reset checked");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
